// File: rtl/vga_camera_pkg.sv
// Shared state type, width helpers and luma quantiser for the camera capture path.
package vga_camera_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Widest coordinate the frame buffer addressing supports.
    localparam int MAX_COORD_W = 16;

    // Width needed to index n positions, never less than one bit.
    function automatic int coord_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Keeps the top out_w bits of a data_w-bit sample, optionally inverted.
    function automatic logic [31:0] quantise(input logic [31:0] data,
                                             input int          data_w,
                                             input int          out_w,
                                             input logic        invert);
        logic [31:0] mask;
        logic [31:0] q;
        mask = (32'd1 << out_w) - 32'd1;
        q    = (data >> (data_w - out_w)) & mask;
        return invert ? (q ^ mask) : q;
    endfunction

endpackage

// File: rtl/vga_camera_edge.sv
// Registered rise/fall detector: compares a level against its value one clock earlier.
module vga_camera_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/vga_camera_capture.sv
// Captures the luma of a YUV422 camera stream, decimates it horizontally and
// emits quantised pixels with coordinates, frame pulses and sticky geometry errors.
module vga_camera_capture
    import vga_camera_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OUT_W         = 2,
    parameter int BYTES_PER_PIX = 2,
    parameter int Y_BYTE        = 1,
    parameter int DECIM         = 4,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter bit INVERT        = 1'b1
) (
    input  logic                               pclk,
    input  logic                               reset_n,
    input  logic [DATA_W-1:0]                  data_in,
    input  logic                               h_ref,
    input  logic                               v_sync,
    input  logic                               capture_en,
    input  logic                               single_shot,
    input  logic                               err_clr,
    output logic [OUT_W-1:0]                   pix_data,
    output logic                               pix_valid,
    output logic [coord_w(H_ACTIVE/DECIM)-1:0] pix_x,
    output logic [coord_w(V_ACTIVE)-1:0]       pix_y,
    output logic                               frame_start,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               line_err,
    output logic                               frame_err
);

    localparam int X_W      = coord_w(H_ACTIVE / DECIM);
    localparam int Y_W      = coord_w(V_ACTIVE);
    localparam int COL_W    = $clog2(H_ACTIVE + 2);
    localparam int ROW_W    = $clog2(V_ACTIVE + 2);
    localparam int PH_W     = coord_w(BYTES_PER_PIX);
    localparam int DECIM_SH = $clog2(DECIM);

    localparam logic [COL_W-1:0] H_LIM      = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_MAX    = COL_W'(H_ACTIVE + 1);
    localparam logic [COL_W-1:0] DECIM_MASK = COL_W'(DECIM - 1);
    localparam logic [ROW_W-1:0] V_LIM      = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(V_ACTIVE + 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(BYTES_PER_PIX - 1);
    localparam logic [PH_W-1:0]  PH_LUMA    = PH_W'(Y_BYTE);

    if (X_W > MAX_COORD_W || Y_W > MAX_COORD_W) begin : g_width_check
        $error("vga_camera_capture: coordinate width exceeds MAX_COORD_W");
    end

    logic hr_rise_unused;
    logic hr_fall;
    logic vs_rise;
    logic vs_fall;

    vga_camera_edge u_href_edge (
        .clk   (pclk),
        .rst_n (reset_n),
        .sig   (h_ref),
        .rise  (hr_rise_unused),
        .fall  (hr_fall)
    );

    vga_camera_edge u_vsync_edge (
        .clk   (pclk),
        .rst_n (reset_n),
        .sig   (v_sync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    cap_state_e        state_q,       state_d;
    logic [PH_W-1:0]   phase_q,       phase_d;
    logic [COL_W-1:0]  col_q,         col_d;
    logic [ROW_W-1:0]  row_q,         row_d;
    logic [OUT_W-1:0]  pix_data_q,    pix_data_d;
    logic              pix_valid_q,   pix_valid_d;
    logic [X_W-1:0]    pix_x_q,       pix_x_d;
    logic [Y_W-1:0]    pix_y_q,       pix_y_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q,  frame_done_d;
    logic              line_err_q,    line_err_d;
    logic              frame_err_q,   frame_err_d;
    logic              emit;

    always_comb begin
        state_d       = state_q;
        phase_d       = '0;
        col_d         = col_q;
        row_d         = row_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q & ~err_clr;
        frame_err_d   = frame_err_q & ~err_clr;
        emit          = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_en) state_d = ARMED;
            end
            ARMED: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    state_d       = CAPTURE;
                    frame_start_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (h_ref) begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    emit    = (phase_q == PH_LUMA) && ((col_q & DECIM_MASK) == '0) &&
                              (col_q < H_LIM) && (row_q < V_LIM);
                    if (phase_q == PH_LAST && col_q != COL_MAX) col_d = col_q + 1'b1;
                end
                // Line end is resolved before the frame end so a coincident
                // v_sync rise sees the row count including the closing line.
                if (hr_fall) begin
                    if (col_q != H_LIM) line_err_d = 1'b1;
                    col_d = '0;
                    if (row_q != ROW_MAX) row_d = row_q + 1'b1;
                end
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    if (row_d != V_LIM) frame_err_d = 1'b1;
                    state_d = (single_shot || !capture_en) ? IDLE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != CAPTURE) begin
            phase_d = '0;
            col_d   = '0;
            row_d   = '0;
        end

        if (emit) begin
            pix_valid_d = 1'b1;
            pix_x_d     = X_W'(col_q >> DECIM_SH);
            pix_y_d     = Y_W'(row_q);
            pix_data_d  = OUT_W'(quantise(32'(data_in), DATA_W, OUT_W, INVERT));
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vga_camera_capture.sv
// Bench for vga_camera_capture: randomised frames checked against a pixel-list model.
module tb_vga_camera_capture;

    localparam int H_T = 8;
    localparam int V_T = 2;
    localparam int D_T = 4;

    logic       pclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       h_ref = 1'b0;
    logic       v_sync = 1'b1;
    logic       capture_en = 1'b0;
    logic       single_shot = 1'b0;
    logic       err_clr = 1'b0;

    logic [1:0] m_data, a_data, b_data;
    logic       m_valid, a_valid, b_valid;
    logic [0:0] m_x;
    logic [2:0] a_x, b_x;
    logic [0:0] m_y, a_y, b_y;
    logic       m_fs, m_fd, m_busy, m_lerr, m_ferr;
    logic       a_fs, a_fd, a_busy, a_lerr, a_ferr;
    logic       b_fs, b_fd, b_busy, b_lerr, b_ferr;

    vga_camera_capture #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .DECIM(D_T), .OUT_W(2),
                         .INVERT(1'b1), .BYTES_PER_PIX(2), .Y_BYTE(1)) dut (
        .pclk(pclk), .reset_n(reset_n), .data_in(data_in), .h_ref(h_ref), .v_sync(v_sync),
        .capture_en(capture_en), .single_shot(single_shot), .err_clr(err_clr),
        .pix_data(m_data), .pix_valid(m_valid), .pix_x(m_x), .pix_y(m_y),
        .frame_start(m_fs), .frame_done(m_fd), .busy(m_busy), .line_err(m_lerr), .frame_err(m_ferr));

    vga_camera_capture #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .DECIM(1), .OUT_W(2),
                         .INVERT(1'b1), .BYTES_PER_PIX(2), .Y_BYTE(1)) dut_q_inv (
        .pclk(pclk), .reset_n(reset_n), .data_in(data_in), .h_ref(h_ref), .v_sync(v_sync),
        .capture_en(capture_en), .single_shot(single_shot), .err_clr(err_clr),
        .pix_data(a_data), .pix_valid(a_valid), .pix_x(a_x), .pix_y(a_y),
        .frame_start(a_fs), .frame_done(a_fd), .busy(a_busy), .line_err(a_lerr), .frame_err(a_ferr));

    vga_camera_capture #(.H_ACTIVE(H_T), .V_ACTIVE(V_T), .DECIM(1), .OUT_W(2),
                         .INVERT(1'b0), .BYTES_PER_PIX(2), .Y_BYTE(1)) dut_q_pos (
        .pclk(pclk), .reset_n(reset_n), .data_in(data_in), .h_ref(h_ref), .v_sync(v_sync),
        .capture_en(capture_en), .single_shot(single_shot), .err_clr(err_clr),
        .pix_data(b_data), .pix_valid(b_valid), .pix_x(b_x), .pix_y(b_y),
        .frame_start(b_fs), .frame_done(b_fd), .busy(b_busy), .line_err(b_lerr), .frame_err(b_ferr));

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
    } pix_t;

    pix_t       obs_m[$], obs_a[$], obs_b[$];
    pix_t       exp_m[$], exp_a[$], exp_b[$];
    int         fs_cnt, fd_cnt, fd_cyc, vs_cyc;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_lines;
    int         len[4];
    logic [7:0] ly[4][16];
    bit         sim_end = 1'b0;
    bit         drop_en = 1'b0;
    logic       busy_at_fd;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (m_valid) obs_m.push_back({8'(m_x), 8'(m_y), 8'(m_data)});
        if (a_valid) obs_a.push_back({8'(a_x), 8'(a_y), 8'(a_data)});
        if (b_valid) obs_b.push_back({8'(b_x), 8'(b_y), 8'(b_data)});
        if (m_fs) fs_cnt++;
        if (m_fd) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_obs();
        obs_m.delete(); obs_a.delete(); obs_b.delete();
        fs_cnt = 0;
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    task automatic set_frame(input int nl, input int l0, input int l1, input int l2);
        n_lines = nl;
        len[0] = l0; len[1] = l1; len[2] = l2; len[3] = 0;
        for (int l = 0; l < 4; l++)
            for (int p = 0; p < 16; p++)
                ly[l][p] = 8'($urandom_range(0, 255));
    endtask

    // Reference: every pixel that lands inside the active window is a candidate;
    // the decimated stream keeps every D_T-th one. Code is the top two bits of luma.
    task automatic build_model();
        int q;
        exp_m.delete(); exp_a.delete(); exp_b.delete();
        for (int l = 0; l < n_lines; l++) begin
            for (int p = 0; p < len[l]; p++) begin
                q = int'(ly[l][p]) / 64;
                if (p < H_T && l < V_T) begin
                    if (p % D_T == 0) exp_m.push_back({8'(p / D_T), 8'(l), 8'(3 - q)});
                    exp_a.push_back({8'(p), 8'(l), 8'(3 - q)});
                    exp_b.push_back({8'(p), 8'(l), 8'(q)});
                end
            end
        end
    endtask

    task automatic send_line(input int l, input bit last);
        for (int p = 0; p < len[l]; p++) begin
            h_ref = 1'b1;
            data_in = 8'($urandom_range(0, 255));
            tick();
            data_in = ly[l][p];
            tick();
        end
        if (!(last && sim_end)) begin
            h_ref = 1'b0;
            data_in = 8'h00;
            tick();
            tick();
        end
    endtask

    task automatic send_frame();
        v_sync = 1'b1;
        h_ref = 1'b0;
        repeat (3) tick();
        v_sync = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < n_lines; l++) send_line(l, l == n_lines - 1);
        h_ref = 1'b0;
        v_sync = 1'b1;
        vs_cyc = cyc;
        tick();
        if (drop_en) begin
            busy_at_fd = m_busy;
            capture_en = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [12:0] all_out;
        reset_n = 1'b0;
        repeat (3) tick();
        all_out = {m_data, m_valid, m_x, m_y, m_fs, m_fd, m_busy, m_lerr, m_ferr, a_valid, b_valid};
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out);
        else n_pass++;
        reset_n = 1'b1;
        capture_en = 1'b1;
        tick();
        tick();
        n_checks++;
        if (m_busy !== 1'b1) $display("FAIL reset_arm_busy: got %b expected 1", m_busy);
        else n_pass++;
    endtask

    task automatic test_nominal();
        for (int rep = 0; rep < 2; rep++) begin
            clear_obs();
            set_frame(2, 8, 8, 0);
            if (rep == 0) begin
                for (int l = 0; l < 2; l++)
                    for (int p = 0; p < 8; p++) ly[l][p] = 8'(8'h10 + 8'h40 * (p % 4));
            end
            build_model();
            send_frame();
            n_checks++;
            if (fs_cnt !== 1) $display("FAIL nominal_frame_start: got %0d expected 1", fs_cnt);
            else n_pass++;
            n_checks++;
            if (fd_cnt !== 1) $display("FAIL nominal_frame_done: got %0d expected 1", fd_cnt);
            else n_pass++;
            n_checks++;
            if (fd_cyc !== vs_cyc + 1) $display("FAIL nominal_done_latency: got cycle %0d expected %0d", fd_cyc, vs_cyc + 1);
            else n_pass++;
            n_checks++;
            if (obs_m.size() !== exp_m.size()) $display("FAIL nominal_pix_count: got %0d expected %0d", obs_m.size(), exp_m.size());
            else n_pass++;
            foreach (exp_m[i]) begin
                n_checks++;
                if (obs_m[i] !== exp_m[i]) $display("FAIL nominal_pix[%0d]: got %h expected %h", i, obs_m[i], exp_m[i]);
                else n_pass++;
            end
            if (rep == 0) begin
                n_checks++;
                if (obs_m[0].d !== 8'd3) $display("FAIL nominal_first_code: got %0d expected 3", obs_m[0].d);
                else n_pass++;
            end
            n_checks++;
            if ({m_lerr, m_ferr, m_busy} !== 3'b001) $display("FAIL nominal_flags: got %b expected 001", {m_lerr, m_ferr, m_busy});
            else n_pass++;
        end
    endtask

    task automatic test_quantise();
        logic [7:0] sweep[6];
        int         inv_code[6];
        int         pos_code[6];
        sweep = '{8'h00, 8'h3F, 8'h40, 8'h80, 8'hC0, 8'hFF};
        inv_code = '{3, 3, 2, 1, 0, 0};
        pos_code = '{0, 0, 1, 2, 3, 3};
        clear_obs();
        set_frame(2, 8, 8, 0);
        for (int p = 0; p < 6; p++) ly[0][p] = sweep[p];
        build_model();
        send_frame();
        for (int p = 0; p < 6; p++) begin
            n_checks++;
            if (obs_a[p].d !== 8'(inv_code[p])) $display("FAIL quant_inv[%0d]: got %0d expected %0d", p, obs_a[p].d, inv_code[p]);
            else n_pass++;
            n_checks++;
            if (obs_b[p].d !== 8'(pos_code[p])) $display("FAIL quant_pos[%0d]: got %0d expected %0d", p, obs_b[p].d, pos_code[p]);
            else n_pass++;
        end
        n_checks++;
        if (obs_a.size() !== exp_a.size() || obs_b.size() !== exp_b.size())
            $display("FAIL quant_count: got %0d/%0d expected %0d/%0d", obs_a.size(), obs_b.size(), exp_a.size(), exp_b.size());
        else n_pass++;
        foreach (exp_a[i]) begin
            n_checks++;
            if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i])
                $display("FAIL quant_pix[%0d]: got %h/%h expected %h/%h", i, obs_a[i], obs_b[i], exp_a[i], exp_b[i]);
            else n_pass++;
        end
    endtask

    task automatic test_errors();
        clear_obs();
        set_frame(3, 6, 12, 8);
        build_model();
        send_frame();
        n_checks++;
        if ({m_lerr, m_ferr} !== 2'b11) $display("FAIL err_set: got %b expected 11", {m_lerr, m_ferr});
        else n_pass++;
        n_checks++;
        if (obs_m.size() !== exp_m.size()) $display("FAIL err_pix_count: got %0d expected %0d", obs_m.size(), exp_m.size());
        else n_pass++;
        foreach (exp_m[i]) begin
            n_checks++;
            if (obs_m[i] !== exp_m[i]) $display("FAIL err_pix[%0d]: got %h expected %h", i, obs_m[i], exp_m[i]);
            else n_pass++;
        end
        set_frame(2, 8, 8, 0);
        send_frame();
        n_checks++;
        if ({m_lerr, m_ferr} !== 2'b11) $display("FAIL err_sticky: got %b expected 11", {m_lerr, m_ferr});
        else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        n_checks++;
        if ({m_lerr, m_ferr} !== 2'b00) $display("FAIL err_clear: got %b expected 00", {m_lerr, m_ferr});
        else n_pass++;
    endtask

    task automatic test_single_shot();
        clear_obs();
        single_shot = 1'b1;
        drop_en = 1'b1;
        set_frame(2, 8, 8, 0);
        build_model();
        send_frame();
        drop_en = 1'b0;
        n_checks++;
        if (busy_at_fd !== 1'b0) $display("FAIL single_busy_after_done: got %b expected 0", busy_at_fd);
        else n_pass++;
        n_checks++;
        if (obs_m.size() !== exp_m.size()) $display("FAIL single_pix_count: got %0d expected %0d", obs_m.size(), exp_m.size());
        else n_pass++;
        foreach (exp_m[i]) begin
            n_checks++;
            if (obs_m[i] !== exp_m[i]) $display("FAIL single_pix[%0d]: got %h expected %h", i, obs_m[i], exp_m[i]);
            else n_pass++;
        end
        clear_obs();
        set_frame(2, 8, 8, 0);
        send_frame();
        n_checks++;
        if (obs_m.size() !== 0 || fd_cnt !== 0 || m_busy !== 1'b0)
            $display("FAIL single_second_frame: got pix=%0d done=%0d busy=%b expected 0 0 0", obs_m.size(), fd_cnt, m_busy);
        else n_pass++;
        single_shot = 1'b0;
        capture_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_midline();
        logic [12:0] all_out;
        set_frame(2, 8, 8, 0);
        ly[0][0] = 8'h10;
        v_sync = 1'b1;
        repeat (3) tick();
        v_sync = 1'b0;
        repeat (2) tick();
        for (int p = 0; p < 3; p++) begin
            h_ref = 1'b1;
            data_in = 8'($urandom_range(0, 255));
            tick();
            data_in = ly[0][p];
            tick();
        end
        n_checks++;
        if ({m_busy, m_data} !== 3'b111) $display("FAIL midline_pre_reset: got %b expected 111", {m_busy, m_data});
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        all_out = {m_data, m_valid, m_x, m_y, m_fs, m_fd, m_busy, m_lerr, m_ferr, a_valid, b_valid};
        n_checks++;
        if (all_out !== '0) $display("FAIL midline_async_reset: got %h expected 0", all_out);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        clear_obs();
        for (int p = 3; p < 8; p++) begin
            data_in = 8'($urandom_range(0, 255));
            tick();
            data_in = ly[0][p];
            tick();
        end
        h_ref = 1'b0;
        tick();
        tick();
        send_line(1, 1'b0);
        v_sync = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (obs_m.size() !== 0 || fs_cnt !== 0 || fd_cnt !== 0)
            $display("FAIL midline_no_resume: got pix=%0d start=%0d done=%0d expected 0 0 0", obs_m.size(), fs_cnt, fd_cnt);
        else n_pass++;
        clear_obs();
        set_frame(2, 8, 8, 0);
        build_model();
        send_frame();
        n_checks++;
        if (fs_cnt !== 1 || obs_m.size() !== exp_m.size())
            $display("FAIL midline_resume: got start=%0d pix=%0d expected 1 %0d", fs_cnt, obs_m.size(), exp_m.size());
        else n_pass++;
        foreach (exp_m[i]) begin
            n_checks++;
            if (obs_m[i] !== exp_m[i]) $display("FAIL midline_pix[%0d]: got %h expected %h", i, obs_m[i], exp_m[i]);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous_end();
        clear_obs();
        sim_end = 1'b1;
        set_frame(2, 8, 8, 0);
        build_model();
        send_frame();
        sim_end = 1'b0;
        n_checks++;
        if (fd_cnt !== 1) $display("FAIL simul_frame_done: got %0d expected 1", fd_cnt);
        else n_pass++;
        n_checks++;
        if ({m_lerr, m_ferr} !== 2'b00) $display("FAIL simul_errors: got %b expected 00", {m_lerr, m_ferr});
        else n_pass++;
        n_checks++;
        if (obs_m.size() !== exp_m.size()) $display("FAIL simul_pix_count: got %0d expected %0d", obs_m.size(), exp_m.size());
        else n_pass++;
        foreach (exp_m[i]) begin
            n_checks++;
            if (obs_m[i] !== exp_m[i]) $display("FAIL simul_pix[%0d]: got %h expected %h", i, obs_m[i], exp_m[i]);
            else n_pass++;
        end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_nominal();
        test_quantise();
        test_errors();
        test_single_shot();
        test_reset_midline();
        test_simultaneous_end();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_camera_capture.md
Name: vga_camera_capture

Overview:
- Parametrised successor to the single-mode camera quantiser. Captures the YUV422 byte stream of an OV7670-class sensor in the pclk domain.
- Frames are bounded by v_sync and lines by h_ref. The block extracts the luma byte of each pixel, decimates horizontally and quantises to OUT_W bits.
- It emits a valid-strobed pixel stream with x/y coordinates, frame start/done pulses and sticky geometry-error flags.
- It sits between the sensor pins and the frame buffer / VGA driver.

Parameters:
- DATA_W, 8, sensor data bus width
- OUT_W, 2, quantised pixel width (1..DATA_W)
- BYTES_PER_PIX, 2, bytes per pixel on the bus (1..4)
- Y_BYTE, 1, byte index within a pixel that carries luma (< BYTES_PER_PIX)
- DECIM, 4, horizontal decimation: emit every DECIM-th pixel (power of 2)
- H_ACTIVE, 640, expected pixels per line
- V_ACTIVE, 480, expected lines per frame
- INVERT, 1, 1 = dark maps to all-ones code (legacy colour mapping)

Ports:
- pclk  in  1  sensor pixel clock, sole clock
- reset_n  in  1  asynchronous active-low reset
- data_in  in  DATA_W  sensor data
- h_ref  in  1  line-valid, high while bytes are valid
- v_sync  in  1  vertical sync, high during vertical blanking
- capture_en  in  1  level: enable capture
- single_shot  in  1  level: return to IDLE after one frame
- err_clr  in  1  pulse: clear sticky errors
- pix_data  out  OUT_W  quantised pixel
- pix_valid  out  1  pix_data/pix_x/pix_y valid this cycle
- pix_x  out  $clog2(H_ACTIVE/DECIM)  decimated column
- pix_y  out  $clog2(V_ACTIVE)  row
- frame_start  out  1  one-cycle pulse
- frame_done  out  1  one-cycle pulse
- busy  out  1  state != IDLE
- line_err  out  1  sticky: a line had pixel count != H_ACTIVE
- frame_err  out  1  sticky: a frame had line count != V_ACTIVE

Behaviour:
- All inputs are sampled on posedge pclk. Registered copies h_ref_d and v_sync_d give the edges:
  - hr_rise = h_ref & ~h_ref_d
  - hr_fall = ~h_ref & h_ref_d
  - vs_rise = v_sync & ~v_sync_d
  - vs_fall = ~v_sync & v_sync_d
- Reset (async): state = IDLE. All outputs, counters and edge registers are 0.
- States:
  - IDLE: when capture_en = 1, go to ARMED next cycle.
  - ARMED: wait for vs_fall. On vs_fall, go to CAPTURE, pulse frame_start in the same registered cycle, clear col and row. If capture_en = 0, return to IDLE.
  - CAPTURE:
    - On vs_rise: pulse frame_done. If row != V_ACTIVE, set frame_err.
    - Then go to IDLE if single_shot = 1 or capture_en = 0, else go to ARMED.
    - Deasserting capture_en mid-frame does not abort; the current frame completes.
- Byte phase counter (mod BYTES_PER_PIX):
  - Cleared whenever h_ref = 0.
  - Increments on each h_ref = 1 cycle.
  - The pixel completes when phase = BYTES_PER_PIX-1. col increments then.
- Emission:
  - Condition: CAPTURE, h_ref = 1, phase = Y_BYTE, col % DECIM = 0, col < H_ACTIVE, row < V_ACTIVE.
  - When met, the next cycle has pix_valid = 1 with pix_x = col/DECIM and pix_y = row. Latency is 1 pclk from the sampling edge.
  - pix_valid is otherwise 0. pix_data holds its last value.
- Quantise:
  - q = data_in[DATA_W-1 -: OUT_W], i.e. uniform bins of width 2^(DATA_W-OUT_W).
  - pix_data = INVERT ? ~q : q.
- Line end: on hr_fall in CAPTURE, if col != H_ACTIVE set line_err. Then col = 0 and row = row + 1.
- Saturation: col saturates at H_ACTIVE+1 and row at V_ACTIVE+1. Over-length lines and frames never wrap and never emit.
- Simultaneous hr_fall and vs_rise: the line end is processed first, so frame_err compares against the incremented row.
- err_clr has priority below a same-cycle error set: the error remains set.
- h_ref activity outside CAPTURE is ignored; counters hold at 0.

Decomposition:
- Package vga_camera_pkg holds:
  - state enum {IDLE, ARMED, CAPTURE}
  - a quantise(data, invert) function
  - localparams for the coordinate widths
- Natural sub-module: vga_camera_edge, a registered rise/fall detector instanced for h_ref and v_sync.

Test Plan:
- Bench override for all scenarios: H_ACTIVE=8, V_ACTIVE=2, DECIM=4, OUT_W=2, INVERT=1, BYTES_PER_PIX=2, Y_BYTE=1.
- Nominal frame: v_sync 1→0, then 2 lines of 16 bytes with Y bytes 0x10,0x50,0x90,0xD0,... → frame_start once. Per line, pix_valid exactly twice, at x=0 (pix_data=2'b11 for 0x10) and x=1 (pixel 4). frame_done on v_sync rise. No errors.
- Quantise sweep (DECIM=1 variant): Y bytes 0x00, 0x3F, 0x40, 0x80, 0xC0, 0xFF → pix_data 11, 11, 10, 01, 00, 00. Repeat with INVERT=0 → 00, 00, 01, 10, 11, 11.
- Short line of 6 pixels, then long frame of 3 lines → line_err = 1 and frame_err = 1. Both stay set after the next clean frame. err_clr clears both. The 3rd line emits nothing.
- single_shot=1 with 2 frames sent → only the first frame is captured. busy = 0 after frame_done. The second frame produces no pix_valid.
- reset_n pulsed low mid-line → all outputs 0 immediately with no pclk edge. Capture resumes only at the next v_sync falling edge.
- hr_fall and vs_rise in the same cycle on line 2 → row=2, frame_err stays 0, frame_done pulses once.
